// File: rtl/iic_target.sv
// I2C target with a fixed 7-bit address. SCK/SDA are oversampled on the system clock;
// written bytes come out on rx_data/rx_valid and read bytes are fetched from tx_data.
module iic_target #(
    parameter logic [6:0]  ADDR        = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sck_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    output logic       addressed,
    output logic       rw,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       tx_nack
);

    typedef enum logic [2:0] {
        IDLE, ADDR_BYTE, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sck_sync, sda_sync;
    logic       sck_prev, sda_prev;
    logic       sck_s, sda_s;
    logic       sck_rise, sck_fall, start_det, stop_det;

    logic [2:0] bitcnt, bitcnt_n;
    logic [7:0] shift, shift_n;
    logic       ack_seen, ack_seen_n;
    logic       sda_oe_n, busy_n, addressed_n, rw_n;
    logic [7:0] rx_data_n;
    logic       rx_valid_n, tx_load_n, tx_nack_n;

    // Pin synchronisers plus history flop; reset to the idle-bus level to avoid false events.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_sync <= '1;
            sda_sync <= '1;
            sck_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            sck_prev <= sck_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev;
    assign sck_fall  = ~sck_s & sck_prev;
    assign start_det = sck_s & sda_prev & ~sda_s;
    assign stop_det  = sck_s & ~sda_prev & sda_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bitcnt    <= 3'd0;
            shift     <= 8'h00;
            ack_seen  <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            addressed <= 1'b0;
            rw        <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
            tx_nack   <= 1'b0;
        end else begin
            state     <= state_n;
            bitcnt    <= bitcnt_n;
            shift     <= shift_n;
            ack_seen  <= ack_seen_n;
            sda_oe    <= sda_oe_n;
            busy      <= busy_n;
            addressed <= addressed_n;
            rw        <= rw_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            tx_load   <= tx_load_n;
            tx_nack   <= tx_nack_n;
        end
    end

    // Bus protocol; START/STOP override whatever the current state is doing.
    always_comb begin
        state_n     = state;
        bitcnt_n    = bitcnt;
        shift_n     = shift;
        ack_seen_n  = ack_seen;
        sda_oe_n    = sda_oe;
        busy_n      = busy;
        addressed_n = addressed;
        rw_n        = rw;
        rx_data_n   = rx_data;
        rx_valid_n  = 1'b0;
        tx_load_n   = 1'b0;
        tx_nack_n   = 1'b0;

        if (start_det) begin
            state_n     = ADDR_BYTE;
            bitcnt_n    = 3'd0;
            sda_oe_n    = 1'b0;
            addressed_n = 1'b0;
            busy_n      = 1'b1;
            ack_seen_n  = 1'b0;
        end else if (stop_det) begin
            state_n     = IDLE;
            sda_oe_n    = 1'b0;
            busy_n      = 1'b0;
            addressed_n = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ADDR_BYTE: begin
                    if (sck_rise) begin
                        shift_n  = {shift[6:0], sda_s};
                        bitcnt_n = bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            // General call (address 0) is never answered.
                            if (shift[6:0] == ADDR && ADDR != 7'd0) begin
                                rw_n    = sda_s;
                                state_n = ADDR_ACK;
                            end else begin
                                state_n = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (sck_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n    = 1'b1;
                            addressed_n = 1'b1;
                        end else if (!rw) begin
                            sda_oe_n = 1'b0;
                            bitcnt_n = 3'd0;
                            state_n  = WRITE;
                        end else begin
                            tx_load_n = 1'b1;
                            shift_n   = tx_data;
                            sda_oe_n  = ~tx_data[7];
                            bitcnt_n  = 3'd0;
                            state_n   = READ;
                        end
                    end
                end
                WRITE: begin
                    if (sck_rise) begin
                        shift_n  = {shift[6:0], sda_s};
                        bitcnt_n = bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            rx_data_n  = {shift[6:0], sda_s};
                            rx_valid_n = 1'b1;
                            state_n    = WRITE_ACK;
                        end
                    end
                end
                WRITE_ACK: begin
                    if (sck_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            sda_oe_n = 1'b0;
                            bitcnt_n = 3'd0;
                            state_n  = WRITE;
                        end
                    end
                end
                READ: begin
                    // bitcnt counts bits already clocked out; wrap to 0 marks the byte end.
                    if (sck_rise) begin
                        bitcnt_n = bitcnt + 3'd1;
                    end else if (sck_fall) begin
                        if (bitcnt == 3'd0) begin
                            sda_oe_n   = 1'b0;
                            ack_seen_n = 1'b0;
                            state_n    = READ_ACK;
                        end else begin
                            sda_oe_n = ~shift[~bitcnt];
                        end
                    end
                end
                READ_ACK: begin
                    if (sck_rise) begin
                        if (sda_s) begin
                            tx_nack_n   = 1'b1;
                            addressed_n = 1'b0;
                            state_n     = IGNORE;
                        end else begin
                            ack_seen_n = 1'b1;
                        end
                    end else if (sck_fall && ack_seen) begin
                        tx_load_n = 1'b1;
                        shift_n   = tx_data;
                        sda_oe_n  = ~tx_data[7];
                        bitcnt_n  = 3'd0;
                        state_n   = READ;
                    end
                end
                IGNORE: begin
                    sda_oe_n = 1'b0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
